// File: rtl/gsim_pkg.sv
// Shared definitions for the GSIM solver and its b-vector loader.
package gsim_pkg;

  localparam int GSIM_N   = 16;
  localparam int GSIM_RUN = 69;
  localparam int GSIM_BW  = 16;
  localparam int GSIM_XW  = 32;

  typedef enum logic [2:0] {
    LD_FILL,
    LD_ARM,
    LD_GAP,
    LD_SEND,
    LD_WAIT
  } gsim_ld_state_t;

endpackage

// File: rtl/gsim_vec_buf.sv
// One-vector b buffer: N words, one write port, one combinational read port.
module gsim_vec_buf
  import gsim_pkg::*;
#(
  parameter int N  = GSIM_N,
  parameter int W  = GSIM_BW,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/gsim_b_loader.sv
// Buffers one N-word b vector, re-arms GSIM, streams the vector as one
// contiguous in_en burst, then waits for GSIM's out_valid burst or a timeout.
module gsim_b_loader
  import gsim_pkg::*;
#(
  parameter int N       = GSIM_N,
  parameter int TIMEOUT = 2000,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  input  logic [GSIM_BW-1:0]  s_data,
  output logic                s_ready,
  output logic                gsim_rst,
  output logic                in_en,
  output logic [GSIM_BW-1:0]  b_out,
  input  logic                out_valid,
  output logic                vec_done,
  output logic                err
);

  localparam int            CW    = $clog2(N);
  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  gsim_ld_state_t state_q, state_d;

  logic [CW-1:0]      wcnt_q, wcnt_d;
  logic [CW-1:0]      rcnt_q, rcnt_d;
  logic [CW-1:0]      ocnt_q, ocnt_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic               in_en_q, in_en_d;
  logic               gsim_rst_q, gsim_rst_d;
  logic               vec_done_q, vec_done_d;
  logic               err_q, err_d;
  logic [GSIM_BW-1:0] b_out_q, b_out_d;
  logic [GSIM_BW-1:0] rd_data;
  logic               wr_en;
  logic               done;
  logic               tout;

  // Read address is the next-cycle index so b_out can be registered
  // and still line up with in_en.
  gsim_vec_buf #(
    .N (N),
    .W (GSIM_BW)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wcnt_q),
    .wdata (s_data),
    .raddr (rcnt_d),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    ocnt_d  = ocnt_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    done    = 1'b0;
    tout    = 1'b0;

    case (state_q)
      LD_FILL: begin
        if (s_valid) begin
          wr_en  = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST) begin
            wcnt_d  = '0;
            state_d = LD_ARM;
          end
        end
      end
      LD_ARM: state_d = LD_GAP;
      LD_GAP: begin
        rcnt_d  = '0;
        state_d = LD_SEND;
      end
      LD_SEND: begin
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == LAST) state_d = LD_WAIT;
      end
      LD_WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (out_valid) ocnt_d = ocnt_q + 1'b1;
        done = out_valid && (ocnt_q == LAST);
        tout = (tcnt_q == TLAST);
        // Completion takes priority over a coincident timeout.
        if (done || tout) begin
          state_d = LD_FILL;
          wcnt_d  = '0;
          ocnt_d  = '0;
          tcnt_d  = '0;
        end
        if (tout && !done) err_d = 1'b1;
      end
      default: state_d = LD_FILL;
    endcase

    gsim_rst_d = (state_d == LD_ARM);
    in_en_d    = (state_d == LD_SEND);
    b_out_d    = in_en_d ? rd_data : '0;
    vec_done_d = done;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LD_FILL;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      ocnt_q     <= '0;
      tcnt_q     <= '0;
      in_en_q    <= 1'b0;
      gsim_rst_q <= 1'b0;
      vec_done_q <= 1'b0;
      err_q      <= 1'b0;
      b_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      ocnt_q     <= ocnt_d;
      tcnt_q     <= tcnt_d;
      in_en_q    <= in_en_d;
      gsim_rst_q <= gsim_rst_d;
      vec_done_q <= vec_done_d;
      err_q      <= err_d;
      b_out_q    <= b_out_d;
    end
  end

  assign s_ready  = (state_q == LD_FILL);
  assign gsim_rst = gsim_rst_q | reset;
  assign in_en    = in_en_q;
  assign b_out    = b_out_q;
  assign vec_done = vec_done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_gsim_b_loader.sv
// Directed bench for gsim_b_loader: load/send timing, GSIM response, timeout, reset abort.
module tb_gsim_b_loader;

  localparam int TO = 1200;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        gsim_rst;
  logic        in_en;
  logic [15:0] b_out;
  logic        out_valid;
  logic        vec_done;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gsim_b_loader #(
    .N       (16),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .gsim_rst  (gsim_rst),
    .in_en     (in_en),
    .b_out     (b_out),
    .out_valid (out_valid),
    .vec_done  (vec_done),
    .err       (err)
  );

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; s_data = '0; out_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || gsim_rst !== 1'b1 || in_en !== 1'b0 || b_out !== 16'h0 ||
        vec_done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: rdy=%b grst=%b in_en=%b b=%h vd=%b err=%b want 1 1 0 0000 0 0",
               s_ready, gsim_rst, in_en, b_out, vec_done, err);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (gsim_rst !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: grst=%b rdy=%b want 0 1", gsim_rst, s_ready);
    end
  endtask

  // Must be entered on a negedge in FILL. Leaves on the negedge of the first
  // WAIT cycle, or (abort_at >= 0) on the negedge after a mid-SEND reset.
  task automatic test_load_send(input logic [15:0] base, input bit toggle, input bit noise,
                                input bit split, input int abort_at);
    int k = 0;
    int c = 0;
    bit v;
    bit ok = 1'b1;
    bit idled = 1'b0;
    bit aborted = 1'b0;
    logic [15:0] exp;
    while (k < 16 && c < 80) begin
      if (s_ready !== 1'b1 || in_en !== 1'b0) ok = 1'b0;
      if (split && k == 15 && !idled) begin
        s_valid = 1'b0; out_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (s_ready !== 1'b1 || gsim_rst !== 1'b0 || in_en !== 1'b0) ok = 1'b0;
        end
        idled = 1'b1;
      end
      v = !toggle || (c % 2 == 0);
      s_valid = v; s_data = base + 16'(k); out_valid = noise;
      @(negedge clk);
      if (v) k++;
      c++;
    end
    total++;
    if (!ok || k != 16) begin
      bad++;
      $display("FAIL fill_phase base=%h: ok=%b words=%0d want ok=1 words=16", base, ok, k);
    end
    // ARM cycle: junk offered upstream must not be taken.
    s_valid = 1'b1; s_data = 16'hDEAD; out_valid = 1'b0;
    total++;
    if (s_ready !== 1'b0 || gsim_rst !== 1'b1 || in_en !== 1'b0) begin
      bad++;
      $display("FAIL arm: rdy=%b grst=%b in_en=%b want 0 1 0", s_ready, gsim_rst, in_en);
    end
    @(negedge clk);
    total++;
    if (s_ready !== 1'b0 || gsim_rst !== 1'b0 || in_en !== 1'b0 || b_out !== 16'h0) begin
      bad++;
      $display("FAIL gap: rdy=%b grst=%b in_en=%b b=%h want 0 0 0 0000", s_ready, gsim_rst, in_en, b_out);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp = base + 16'(i);
      total++;
      if (in_en !== 1'b1 || b_out !== exp || gsim_rst !== 1'b0 || s_ready !== 1'b0) begin
        bad++;
        $display("FAIL send[%0d]: in_en=%b b=%h grst=%b rdy=%b want 1 %h 0 0",
                 i, in_en, b_out, gsim_rst, s_ready, exp);
      end
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        total++;
        if (in_en !== 1'b0 || b_out !== 16'h0 || gsim_rst !== 1'b1 || s_ready !== 1'b1) begin
          bad++;
          $display("FAIL abort: in_en=%b b=%h grst=%b rdy=%b want 0 0000 1 1",
                   in_en, b_out, gsim_rst, s_ready);
        end
        @(negedge clk);
        reset = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      @(negedge clk);
      s_valid = 1'b0;
      total++;
      if (in_en !== 1'b0 || b_out !== 16'h0 || s_ready !== 1'b0) begin
        bad++;
        $display("FAIL wait_entry: in_en=%b b=%h rdy=%b want 0 0000 0", in_en, b_out, s_ready);
      end
    end
  endtask

  // Entered on the negedge of the first WAIT cycle; out_valid burst starts d cycles later.
  task automatic test_response(input int d, input logic exp_err);
    bit ok = 1'b1;
    out_valid = 1'b0;
    repeat (d) begin
      @(negedge clk);
      if (vec_done !== 1'b0 || s_ready !== 1'b0 || err !== exp_err) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_idle d=%0d: early vec_done/ready/err change", d);
    end
    ok = 1'b1;
    for (int j = 0; j < 16; j++) begin
      out_valid = 1'b1;
      @(negedge clk);
      if (j < 15) begin
        if (vec_done !== 1'b0 || s_ready !== 1'b0) ok = 1'b0;
      end
    end
    out_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ov_count: vec_done or s_ready before 16th out_valid");
    end
    total++;
    if (vec_done !== 1'b1 || s_ready !== 1'b1 || err !== exp_err) begin
      bad++;
      $display("FAIL done d=%0d: vd=%b rdy=%b err=%b want 1 1 %b", d, vec_done, s_ready, err, exp_err);
    end
    @(negedge clk);
    total++;
    if (vec_done !== 1'b0 || s_ready !== 1'b1 || err !== exp_err) begin
      bad++;
      $display("FAIL done_pulse: vd=%b rdy=%b err=%b want 0 1 %b", vec_done, s_ready, err, exp_err);
    end
  endtask

  task automatic test_timeout();
    bit ok = 1'b1;
    test_load_send(16'h0400, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      if (err !== 1'b0 || s_ready !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL timeout_early: err or s_ready rose before %0d WAIT cycles", TO);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b1 || s_ready !== 1'b1 || vec_done !== 1'b0) begin
      bad++;
      $display("FAIL timeout: err=%b rdy=%b vd=%b want 1 1 0", err, s_ready, vec_done);
    end
    ok = 1'b1;
    out_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (err !== 1'b1 || vec_done !== 1'b0 || s_ready !== 1'b1) ok = 1'b0;
    end
    out_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL err_sticky: err=%b vd=%b rdy=%b want 1 0 1", err, vec_done, s_ready);
    end
  endtask

  initial begin
    test_reset();
    // Straight stream 1..16, GSIM answers 1140 cycles after SEND start.
    test_load_send(16'd1, 1'b0, 1'b0, 1'b0, -1);
    test_response(1124, 1'b0);
    // Gappy upstream, stray out_valid during FILL, signed words, immediate answer.
    test_load_send(16'hFFF8, 1'b1, 1'b1, 1'b0, -1);
    test_response(0, 1'b0);
    // 16th out_valid lands on the timeout cycle.
    test_load_send(16'h0100, 1'b0, 1'b0, 1'b0, -1);
    test_response(TO - 16, 1'b0);
    // Reset at rcnt=7, then 15 words must not start a burst.
    test_load_send(16'h0200, 1'b0, 1'b0, 1'b0, 7);
    test_load_send(16'h0300, 1'b0, 1'b0, 1'b1, -1);
    test_response(3, 1'b0);
    test_timeout();
    test_load_send(16'h0500, 1'b1, 1'b0, 1'b0, -1);
    test_response(20, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
